// File: rtl/pa_decode.sv
// Decode / operand-read stage of the pipelined adder: R-type ADD decode, 32x32 register
// file with same-cycle writeback bypass, and a pending-bit scoreboard for RAW hazards.
module pa_decode #(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   instr,
   input  logic [31:0]   in_counter,
   input  logic          wb_en,
   input  logic [4:0]    wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] rs_val,
   output logic [DW-1:0] rt_val,
   output logic [4:0]    rd_addr,
   output logic [31:0]   out_counter,
   output logic          illegal
);

   logic [DW-1:0]   rf_q [NREG];
   logic [NREG-1:0] pend_q;

   logic          out_valid_q, illegal_q;
   logic [DW-1:0] rs_val_q, rt_val_q;
   logic [4:0]    rd_addr_q;
   logic [31:0]   out_counter_q;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt;
   logic       legal, wb_live, byp_rs, byp_rt, hazard, accept;
   logic [DW-1:0] rs_rd, rt_rd;
   logic [DW-1:0] rs_val_d, rt_val_d;
   logic [4:0]    rd_addr_d;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign funct = instr[5:0];

   assign legal   = (op == 6'd0) && (funct == 6'b100000) && (shamt == 5'd0);
   assign wb_live = wb_en && (wb_addr != 5'd0);
   assign byp_rs  = wb_live && (wb_addr == rs);
   assign byp_rt  = wb_live && (wb_addr == rt);

   // r0 reads as zero regardless of what the array holds; a live writeback wins over the array.
   always_comb begin
      rs_rd = rf_q[rs];
      rt_rd = rf_q[rt];
      if (byp_rs)          rs_rd = wb_data;
      if (byp_rt)          rt_rd = wb_data;
      if (rs == 5'd0)      rs_rd = '0;
      if (rt == 5'd0)      rt_rd = '0;
   end

   assign hazard   = legal && ((pend_q[rs] && !byp_rs) || (pend_q[rt] && !byp_rt));
   assign in_ready = !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   assign rs_val_d  = rs_rd;
   assign rt_val_d  = rt_rd;
   assign rd_addr_d = legal ? rd : 5'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= DW'(i);
      end else if (wb_live) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Writeback clears first, so a same-edge accept targeting the same rd keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         logic [NREG-1:0] pend_d;
         pend_d = pend_q;
         if (wb_live) pend_d[wb_addr] = 1'b0;
         if (accept && legal && (rd != 5'd0)) pend_d[rd] = 1'b1;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         rs_val_q      <= '0;
         rt_val_q      <= '0;
         rd_addr_q     <= '0;
         out_counter_q <= '0;
         illegal_q     <= 1'b0;
      end else if (accept) begin
         out_valid_q   <= 1'b1;
         rs_val_q      <= rs_val_d;
         rt_val_q      <= rt_val_d;
         rd_addr_q     <= rd_addr_d;
         out_counter_q <= in_counter;
         illegal_q     <= !legal;
      end else if (out_ready) begin
         out_valid_q   <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign rs_val      = rs_val_q;
   assign rt_val      = rt_val_q;
   assign rd_addr     = rd_addr_q;
   assign out_counter = out_counter_q;
   assign illegal     = illegal_q;

endmodule
